// File: rtl/output_microsequencer_pkg.sv
// output_microsequencer_pkg: shared sequencer states, default sizes and a saturating add helper.
package output_microsequencer_pkg;
  localparam int DW_DEF     = 16;
  localparam int DIM_DEF    = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int CFG_W      = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PSUM,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_COMPLETE
  } state_t;
  function automatic logic signed [DW_DEF-1:0] sat_add(input logic signed [DW_DEF-1:0] a,
                                                       input logic signed [DW_DEF-1:0] b);
    logic signed [DW_DEF:0] s;
    s = {a[DW_DEF-1], a} + {b[DW_DEF-1], b};
    return (s[DW_DEF] != s[DW_DEF-1]) ? {s[DW_DEF], {(DW_DEF-1){~s[DW_DEF]}}} : s[DW_DEF-1:0];
  endfunction
endpackage

// File: rtl/output_microsequencer_psum_sat_add.sv
// output_microsequencer_psum_sat_add: one-lane signed add clamped to the DW-bit range.
module output_microsequencer_psum_sat_add #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [DW-1:0] o_sum
);
  logic signed [DW:0] w_sum;
  assign w_sum = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};
  // Top two bits disagree only on overflow; the sign bit then picks the rail.
  assign o_sum = (w_sum[DW] != w_sum[DW-1]) ? {w_sum[DW], {(DW-1){~w_sum[DW]}}} : w_sum[DW-1:0];
endmodule

// File: rtl/output_microsequencer.sv
// output_microsequencer: writes per-tile psum vectors into lane BRAM banks,
// overwriting on pass 0 and saturating-accumulating on later channel passes.
module output_microsequencer
  import output_microsequencer_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int Dimension = DIM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    restart,
  input  logic [CFG_W-1:0]        out_length,
  input  logic [CFG_W-1:0]        num_channels,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [DW*Dimension-1:0] psum_data,
  output logic [Dimension-1:0]    bram_en,
  output logic [Dimension-1:0]    bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DW*Dimension-1:0] bram_wdata,
  input  logic [DW*Dimension-1:0] bram_rdata,
  output logic                    done
);
  state_t                  r_state;
  logic [ADDR_W-1:0]       r_tile;
  logic [CFG_W-1:0]        r_ch;
  logic [DW*Dimension-1:0] r_latch;
  logic [Dimension-1:0]    w_mask;
  logic [DW*Dimension-1:0] w_pass0;
  logic [DW*Dimension-1:0] w_rmw;
  logic                    w_accept;
  logic                    w_last_tile;
  logic                    w_last_ch;
  logic                    w_empty;

  assign w_accept    = psum_valid & psum_ready;
  assign w_last_tile = (int'(r_tile) + 1) * Dimension >= int'(out_length);
  // num_channels of 0 behaves as a single pass.
  assign w_last_ch   = int'(r_ch) + 1 >= int'(num_channels);
  assign w_empty     = out_length == '0;

  for (genvar i = 0; i < Dimension; i++) begin : g_lane
    logic [DW-1:0] w_sum;
    assign w_mask[i] = (int'(r_tile) * Dimension + i) < int'(out_length);
    output_microsequencer_psum_sat_add #(.DW(DW)) u_add (
      .i_a  (r_latch[DW*i +: DW]),
      .i_b  (bram_rdata[DW*i +: DW]),
      .o_sum(w_sum)
    );
    assign w_pass0[DW*i +: DW] = w_mask[i] ? psum_data[DW*i +: DW] : '0;
    assign w_rmw[DW*i +: DW]   = w_mask[i] ? w_sum : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tile     <= '0;
      r_ch       <= '0;
      r_latch    <= '0;
      psum_ready <= 1'b0;
      bram_en    <= '0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_tile     <= '0;
            r_ch       <= '0;
            r_state    <= w_empty ? S_COMPLETE : S_WAIT_PSUM;
            done       <= w_empty;
            psum_ready <= ~w_empty;
          end
        end
        S_WAIT_PSUM: begin
          if (w_accept) begin
            r_latch    <= psum_data;
            psum_ready <= 1'b0;
            bram_en    <= w_mask;
            bram_addr  <= r_tile;
            // Pass 0 needs no read: the write goes out straight from the incoming psum.
            if (r_ch == '0) begin
              r_state    <= S_WRITE;
              bram_we    <= w_mask;
              bram_wdata <= w_pass0;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          bram_en <= '0;
          r_state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          bram_en    <= w_mask;
          bram_we    <= w_mask;
          bram_wdata <= w_rmw;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          bram_en    <= '0;
          bram_we    <= '0;
          bram_wdata <= '0;
          bram_addr  <= '0;
          if (w_last_tile && w_last_ch) begin
            r_tile  <= '0;
            r_state <= S_COMPLETE;
            done    <= 1'b1;
          end else begin
            r_tile     <= w_last_tile ? '0 : r_tile + 1'b1;
            r_ch       <= w_last_tile ? r_ch + 1'b1 : r_ch;
            r_state    <= S_WAIT_PSUM;
            psum_ready <= 1'b1;
          end
        end
        S_COMPLETE: begin
          if (restart) begin
            r_tile     <= '0;
            r_ch       <= '0;
            r_state    <= w_empty ? S_COMPLETE : S_WAIT_PSUM;
            done       <= w_empty;
            psum_ready <= ~w_empty;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_microsequencer.sv
// tb_output_microsequencer: drives psum tiles into the sequencer against a lane-bank BRAM
// model and a tile/pass accumulation reference.
module tb_output_microsequencer;
  localparam int D = 16;
  localparam logic [15:0] SENT = 16'hA5A5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           restart = 1'b0;
  logic [9:0]     out_length = '0;
  logic [9:0]     num_channels = '0;
  logic           psum_valid = 1'b0;
  logic           psum_ready;
  logic [255:0]   psum_data = '0;
  logic [15:0]    bram_en;
  logic [15:0]    bram_we;
  logic [9:0]     bram_addr;
  logic [255:0]   bram_wdata;
  logic [255:0]   bram_rdata = '0;
  logic           done;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [15:0] mem [D][64];
  logic [15:0] exp_mem [D][64];

  output_microsequencer dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .out_length(out_length), .num_channels(num_channels),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (|bram_we) wr_count <= wr_count + 1;
    for (int i = 0; i < D; i++)
      if (bram_en[i]) begin
        if (bram_we[i]) mem[i][bram_addr[5:0]] <= bram_wdata[16*i +: 16];
        else bram_rdata[16*i +: 16] <= mem[i][bram_addr[5:0]];
      end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [15:0] pval(input int kind, input int c, input int t, input int i);
    case (kind)
      1: return 16'(i + 16 * t);
      2: return 16'd5;
      3: return (c == 0) ? ((i % 2 == 0) ? 16'h0020 : 16'hFFF0)
                         : ((i % 2 == 0) ? 16'h7FF0 : 16'h8005);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_tile(input int len, input int c, input int t, input int kind);
    logic [255:0] pv;
    logic [255:0] ev;
    logic [15:0]  m;
    int n;
    ev = '0;
    for (int i = 0; i < D; i++) begin
      pv[16*i +: 16] = pval(kind, c, t, i);
      m[i] = (t * D + i) < len;
      if (m[i]) begin
        exp_mem[i][t] = (c == 0) ? pv[16*i +: 16] : sat16(exp_mem[i][t], pv[16*i +: 16]);
        ev[16*i +: 16] = exp_mem[i][t];
      end
    end
    psum_data  = pv;
    psum_valid = 1'b1;
    n = 0;
    while (!psum_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 256'(n < 50), 256'(1));
    @(negedge clk);
    chk("ready_drop", 256'(psum_ready), 256'(0));
    // valid stays high through read/wait/write; only the first beat may be taken
    if (c > 0) begin
      chk("rd_en", 256'(bram_en), 256'(m));
      chk("rd_we", 256'(bram_we), 256'(0));
      chk("rd_addr", 256'(bram_addr), 256'(t));
      @(negedge clk);
      chk("rw_en_off", 256'(bram_en), 256'(0));
      @(negedge clk);
    end
    chk("wr_en", 256'(bram_en), 256'(m));
    chk("wr_we", 256'(bram_we), 256'(m));
    chk("wr_addr", 256'(bram_addr), 256'(t));
    chk("wr_data", bram_wdata, ev);
    psum_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input int nch, input int kind, input bit use_restart);
    int passes;
    int nt;
    int w0;
    logic [255:0] mv;
    logic [255:0] ev;
    passes = (nch == 0) ? 1 : nch;
    nt = (len + D - 1) / D;
    w0 = wr_count;
    out_length   = 10'(len);
    num_channels = 10'(nch);
    if (use_restart) restart = 1'b1; else en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    restart = 1'b0;
    if (len == 0) begin
      chk("zero_done", 256'(done), 256'(1));
      repeat (3) @(negedge clk);
      chk("zero_writes", 256'(wr_count - w0), 256'(0));
    end else begin
      chk("start_done_low", 256'(done), 256'(0));
      for (int c = 0; c < passes; c++)
        for (int t = 0; t < nt; t++)
          do_tile(len, c, t, kind);
      @(negedge clk);
      chk("done", 256'(done), 256'(1));
      chk("done_ready_low", 256'(psum_ready), 256'(0));
      chk("write_count", 256'(wr_count - w0), 256'(passes * nt));
      for (int t = 0; t < nt + 1 && t < 64; t++) begin
        for (int i = 0; i < D; i++) begin
          mv[16*i +: 16] = mem[i][t];
          ev[16*i +: 16] = exp_mem[i][t];
        end
        chk("mem_contents", mv, ev);
      end
    end
  endtask

  initial begin
    logic [15:0] keep;
    for (int i = 0; i < D; i++)
      for (int a = 0; a < 64; a++) begin
        mem[i][a] = SENT;
        exp_mem[i][a] = SENT;
      end
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(psum_ready), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_en", 256'(bram_en), 256'(0));
    chk("rst_we", 256'(bram_we), 256'(0));
    chk("rst_addr", 256'(bram_addr), 256'(0));
    chk("rst_wdata", bram_wdata, 256'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_en", 256'(psum_ready), 256'(0));

    run_job(20, 1, 1, 1'b0);
    chk("partial_bank15_untouched", 256'(mem[15][1]), 256'(SENT));
    chk("partial_bank4_untouched", 256'(mem[4][1]), 256'(SENT));
    chk("partial_bank3_written", 256'(mem[3][1]), 256'(19));

    do_reset();
    run_job(32, 1, 1, 1'b0);
    chk("full_tile1_lane15", 256'(mem[15][1]), 256'(31));
    run_job(32, 1, 1, 1'b1);

    do_reset();
    run_job(48, 3, 2, 1'b0);
    chk("accum3_lane0", 256'(mem[0][2]), 256'(15));
    chk("accum3_lane15", 256'(mem[15][0]), 256'(15));

    do_reset();
    run_job(16, 2, 3, 1'b0);
    chk("sat_pos", 256'(mem[0][0]), 256'(16'h7FFF));
    chk("sat_neg", 256'(mem[1][0]), 256'(16'h8000));

    for (int k = 0; k < 4; k++) begin
      do_reset();
      run_job(int'($urandom_range(1, 64)), int'($urandom_range(0, 3)), 0, 1'b0);
    end

    do_reset();
    keep = mem[0][0];
    out_length = 10'd32;
    num_channels = 10'd1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    psum_data = {16{16'h1234}};
    psum_valid = 1'b1;
    @(negedge clk);
    chk("midrun_in_write", 256'(bram_we), 256'(16'hFFFF));
    rst = 1'b0;
    #1;
    chk("midrun_rst_we", 256'(bram_we), 256'(0));
    chk("midrun_rst_en", 256'(bram_en), 256'(0));
    chk("midrun_rst_ready", 256'(psum_ready), 256'(0));
    @(negedge clk);
    psum_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_write_dropped", 256'(mem[0][0]), 256'(keep));
    chk("midrun_idle", 256'(psum_ready), 256'(0));

    run_job(0, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
